ksa: RTL

ARC4 key-scheduling stage: runs directly after `init` has written S[i]=i into the 256-byte S-box RAM. On request it performs the 256-iteration swap pass j = (j + S[i] + key[i mod KEY_LEN]) mod 256, swapping S[i] and S[j] in place. It shares the S-box RAM port with `init` and the later PRGA stage, under the top-level sequencer's control, and reuses the same `en`/`rdy` handshake.

---
 rtl/arc4_pkg.sv | 17 +
 rtl/ksa_key_sel.sv | 51 +++++
 rtl/ksa.sv | 114 +++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 types: S-box geometry, byte type and the key-scheduling state encoding.
package arc4_pkg;

  localparam int unsigned SBOX_SIZE = 256;
  localparam int unsigned BYTE_W    = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_I = 3'd1,
    RD_J = 3'd2,
    WR_I = 3'd3,
    WR_J = 3'd4
  } ksa_state_t;

endpackage

// File: rtl/ksa_key_sel.sv
// Captured cipher key plus the wrapping key-byte index k; presents key byte k.
module ksa_key_sel
  import arc4_pkg::*;
#(
  parameter int unsigned KEY_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  input  logic                 clear,
  input  logic [8*KEY_LEN-1:0] key,
  output byte_t                keybyte
);

  localparam int unsigned KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  logic [8*KEY_LEN-1:0] key_q, key_d;
  logic [KW-1:0]        k_q, k_d;

  // Counter wraps by compare, so no modulo hardware is needed.
  always_comb begin
    key_d = key_q;
    k_d   = k_q;
    if (load) key_d = key;
    if (clear) begin
      k_d = '0;
    end else if (advance) begin
      k_d = (k_q == KW'(KEY_LEN - 1)) ? '0 : k_q + KW'(1);
    end
  end

  // Byte 0 is the most-significant byte of the key.
  always_comb begin
    keybyte = '0;
    for (int unsigned m = 0; m < KEY_LEN; m++) begin
      if (k_q == KW'(m)) keybyte = key_q[8*(KEY_LEN-m)-1 -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      k_q   <= '0;
    end else begin
      key_q <= key_d;
      k_q   <= k_d;
    end
  end

endmodule

// File: rtl/ksa.sv
// ARC4 key-scheduling pass over a synchronous-read S-box RAM.
// Build option KSA_SKIP_SELF_SWAP_EN skips the write pair when j == i.
module ksa
  import arc4_pkg::*;
#(
  parameter int unsigned KEY_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 rdy,
  input  logic [8*KEY_LEN-1:0] key,
  output logic [7:0]           addr,
  input  logic [7:0]           rddata,
  output logic [7:0]           wrdata,
  output logic                 wren
);

  ksa_state_t state_q, state_d;
  byte_t      i_q, i_d;
  byte_t      j_q, j_d;
  byte_t      si_q, si_d;
  byte_t      j_next_c;
  byte_t      keybyte;
  logic       load_c, clear_c, advance_c;
  logic       last_c;

  ksa_key_sel #(.KEY_LEN(KEY_LEN)) u_key_sel (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .advance (advance_c),
    .clear   (clear_c),
    .key     (key),
    .keybyte (keybyte)
  );

  assign last_c = (i_q == byte_t'(SBOX_SIZE - 1));

  // RAM port is driven straight from state so read data can be consumed the cycle it arrives.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    addr      = '0;
    wrdata    = '0;
    wren      = 1'b0;
    rdy       = 1'b0;
    load_c    = 1'b0;
    clear_c   = 1'b0;
    advance_c = 1'b0;
    j_next_c  = j_q + rddata + keybyte;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          load_c  = 1'b1;
          clear_c = 1'b1;
          i_d     = '0;
          j_d     = '0;
          state_d = RD_I;
        end
      end
      RD_I: begin
        addr    = i_q;
        state_d = RD_J;
      end
      RD_J: begin
        si_d    = rddata;
        j_d     = j_next_c;
        addr    = j_next_c;
        state_d = WR_I;
`ifdef KSA_SKIP_SELF_SWAP_EN
        if (j_next_c == i_q) begin
          i_d       = i_q + byte_t'(1);
          advance_c = 1'b1;
          state_d   = last_c ? IDLE : RD_I;
        end
`endif
      end
      WR_I: begin
        addr    = i_q;
        wrdata  = rddata;
        wren    = 1'b1;
        state_d = WR_J;
      end
      WR_J: begin
        addr      = j_q;
        wrdata    = si_q;
        wren      = 1'b1;
        i_d       = i_q + byte_t'(1);
        advance_c = 1'b1;
        state_d   = last_c ? IDLE : RD_I;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
    end
  end

endmodule
